// File: rtl/tvip_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tvip_reset_sequencer
//
// Consumes the active-low reset coming from the testbench reset driver. The
// reset is asserted asynchronously and released synchronously to clk. The
// block then releases NUM_STAGES downstream reset domains one after another,
// STAGE_GAP cycles apart, and raises ready once every domain is out of reset.
// A four-phase soft-reset handshake (req/ack) re-runs the same release
// sequence without a hard reset.
//
// Ports:
//   clk               sole clock, all state on posedge
//   reset_n           asynchronous active-low hard reset
//   soft_reset_req    level soft-reset request, sampled only while READY
//   soft_reset_ack    high once the soft-reset hold time is met, until req drops
//   stage_reset_n     active-low staged resets, bit k = stage k
//   ready             all stages released, sequence complete
//   soft_reset_count  saturating count of accepted soft resets
// -----------------------------------------------------------------------------
module tvip_reset_sequencer #(
    parameter int SYNC_STAGES       = 2,
    parameter int NUM_STAGES        = 3,
    parameter int STAGE_GAP         = 4,
    parameter int SOFT_RESET_CYCLES = 8,
    parameter int COUNT_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   soft_reset_req,
    output logic                   soft_reset_ack,
    output logic [NUM_STAGES-1:0]  stage_reset_n,
    output logic                   ready,
    output logic [COUNT_WIDTH-1:0] soft_reset_count
);

    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int HOLD_W = $clog2(SOFT_RESET_CYCLES + 1);

    localparam logic [GAP_W-1:0]      GAP_LAST     = GAP_W'(STAGE_GAP - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST    = HOLD_W'(SOFT_RESET_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_RELEASED = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE  = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_READY,
        ST_SOFT,
        ST_ACK
    } state_e;

    // ------------------------------------------------------------------
    // Reset synchronizer: a shift chain of ones, cleared by reset_n.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_n;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign sync_d[gi] = 1'b1;
            end else begin : g_tail
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign sync_n = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e                 state_q,  state_d;
    logic [NUM_STAGES-1:0]  stage_q,  stage_d;
    logic                   ready_q,  ready_d;
    logic                   ack_q,    ack_d;
    logic [COUNT_WIDTH-1:0] count_q,  count_d;
    logic [GAP_W-1:0]       gap_q,    gap_d;
    logic [HOLD_W-1:0]      hold_q,   hold_d;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        ready_d = ready_q;
        ack_d   = ack_q;
        count_d = count_q;
        gap_d   = gap_q;
        hold_d  = hold_q;

        case (state_q)
            ST_HOLD: begin
                stage_d = '0;
                ready_d = 1'b0;
                ack_d   = 1'b0;
                if (sync_n) begin
                    stage_d = FIRST_STAGE;
                    gap_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Stages are released strictly in order, so a left shift
                // filling with ones releases the next one; all-ones means the
                // last stage went out on the previous edge.
                if (stage_q == ALL_RELEASED) begin
                    ready_d = 1'b1;
                    state_d = ST_READY;
                end else if (gap_q == GAP_LAST) begin
                    stage_d = (stage_q << 1) | FIRST_STAGE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_READY: begin
                if (soft_reset_req) begin
                    stage_d = '0;
                    ready_d = 1'b0;
                    hold_d  = '0;
                    if (count_q != {COUNT_WIDTH{1'b1}}) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    state_d = ST_SOFT;
                end
            end

            ST_SOFT: begin
                // The request is not looked at here: dropping it early only
                // shortens the ACK phase, never the hold time.
                if (hold_q == HOLD_LAST) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_ACK: begin
                if (!soft_reset_req) begin
                    ack_d   = 1'b0;
                    stage_d = FIRST_STAGE;
                    gap_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= ST_HOLD;
            stage_q <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            count_q <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
        end
    end

    assign stage_reset_n    = stage_q;
    assign ready            = ready_q;
    assign soft_reset_ack   = ack_q;
    assign soft_reset_count = count_q;

endmodule

// File: tb/tb_tvip_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for tvip_reset_sequencer. Three instances share clock, reset and
// request: default parameters, a 2-bit counter variant and a single-stage
// corner variant. Every edge all instances are compared with an event-time
// model (release edge, accept edge, count), plus a power-on vector table and
// hand-written handshake sequences.
// -----------------------------------------------------------------------------
module tb_tvip_reset_sequencer;

    logic clk;
    logic rst_n;
    logic req;

    logic [2:0] st_d;  logic rdy_d;  logic ack_d;  logic [7:0] cnt_d;
    logic [2:0] st_c;  logic rdy_c;  logic ack_c;  logic [1:0] cnt_c;
    logic [0:0] st_k;  logic rdy_k;  logic ack_k;  logic [7:0] cnt_k;

    tvip_reset_sequencer dut_def (
        .clk(clk), .reset_n(rst_n), .soft_reset_req(req),
        .soft_reset_ack(ack_d), .stage_reset_n(st_d), .ready(rdy_d),
        .soft_reset_count(cnt_d)
    );

    tvip_reset_sequencer #(.COUNT_WIDTH(2)) dut_cnt (
        .clk(clk), .reset_n(rst_n), .soft_reset_req(req),
        .soft_reset_ack(ack_c), .stage_reset_n(st_c), .ready(rdy_c),
        .soft_reset_count(cnt_c)
    );

    tvip_reset_sequencer #(.SYNC_STAGES(3), .NUM_STAGES(1), .STAGE_GAP(1)) dut_k (
        .clk(clk), .reset_n(rst_n), .soft_reset_req(req),
        .soft_reset_ack(ack_k), .stage_reset_n(st_k), .ready(rdy_k),
        .soft_reset_count(cnt_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct { int sync; int n; int gap; int src; int cw; } mp_t;
    // mode 0: waiting on synchronizer, 1: releasing / ready, 2: soft hold/ack
    typedef struct { int mode; int h; int t; int rel; int acc; int cnt; } ms_t;
    typedef struct { int stage; int ready; int ack; int cnt; } exp_t;

    mp_t p_d = '{sync: 2, n: 3, gap: 4, src: 8, cw: 8};
    mp_t p_c = '{sync: 2, n: 3, gap: 4, src: 8, cw: 2};
    mp_t p_k = '{sync: 3, n: 1, gap: 1, src: 8, cw: 8};
    ms_t m_d, m_c, m_k;

    function automatic ms_t model_reset(ms_t s);
        s.mode = 0; s.h = 0; s.cnt = 0;
        return s;
    endfunction

    function automatic ms_t model_step(ms_t s, mp_t p, bit rn, bit rq);
        s.t++;
        if (!rn) return model_reset(s);
        s.h++;
        case (s.mode)
            0: if (s.h >= p.sync + 1) begin s.rel = s.t; s.mode = 1; end
            1: if (rq && s.t > s.rel + (p.n - 1) * p.gap + 1) begin
                   s.acc = s.t; s.mode = 2;
                   if (s.cnt < (1 << p.cw) - 1) s.cnt++;
               end
            2: if (!rq && s.t > s.acc + p.src) begin s.rel = s.t; s.mode = 1; end
            default: s.mode = 0;
        endcase
        return s;
    endfunction

    function automatic exp_t model_out(ms_t s, mp_t p);
        exp_t e;
        e.stage = 0; e.ready = 0; e.ack = 0; e.cnt = s.cnt;
        if (s.mode == 1) begin
            for (int k = 0; k < p.n; k++)
                if (s.t >= s.rel + k * p.gap) e.stage |= (1 << k);
            e.ready = (s.t >= s.rel + (p.n - 1) * p.gap + 1) ? 1 : 0;
        end else if (s.mode == 2) begin
            e.ack = (s.t >= s.acc + p.src) ? 1 : 0;
        end
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        e = model_out(m_d, p_d);
        check("def.stage", int'(st_d), e.stage);  check("def.ready", int'(rdy_d), e.ready);
        check("def.ack", int'(ack_d), e.ack);     check("def.count", int'(cnt_d), e.cnt);
        e = model_out(m_c, p_c);
        check("cnt.stage", int'(st_c), e.stage);  check("cnt.ready", int'(rdy_c), e.ready);
        check("cnt.ack", int'(ack_c), e.ack);     check("cnt.count", int'(cnt_c), e.cnt);
        e = model_out(m_k, p_k);
        check("k.stage", int'(st_k), e.stage);    check("k.ready", int'(rdy_k), e.ready);
        check("k.ack", int'(ack_k), e.ack);       check("k.count", int'(cnt_k), e.cnt);
    endtask

    // One clock edge: advance the models with the inputs the DUTs sampled,
    // then compare just after the edge.
    task automatic step();
        @(posedge clk);
        m_d = model_step(m_d, p_d, rst_n, req);
        m_c = model_step(m_c, p_c, rst_n, req);
        m_k = model_step(m_k, p_k, rst_n, req);
        #1;
        compare_all();
    endtask

    task automatic hard_drop();
        rst_n = 1'b0;
        m_d = model_reset(m_d);
        m_c = model_reset(m_c);
        m_k = model_reset(m_k);
    endtask

    // ---------------- power-on vector table ----------------
    typedef struct {
        bit         rn;
        bit         rq;
        logic [2:0] st;
        logic       rdy;
        logic       stk;
        logic       rdyk;
    } pvec_t;

    pvec_t pv[14];

    function automatic pvec_t mk(logic [2:0] st, logic rdy, logic stk, logic rdyk);
        pvec_t v;
        v.rn = 1'b1; v.rq = 1'b0; v.st = st; v.rdy = rdy; v.stk = stk; v.rdyk = rdyk;
        return v;
    endfunction

    task automatic run_power_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            rst_n = pv[i].rn;
            req   = pv[i].rq;
            step();
            check({tag, ".def.stage"}, int'(st_d), int'(pv[i].st));
            check({tag, ".def.ready"}, int'(rdy_d), int'(pv[i].rdy));
            check({tag, ".cnt.stage"}, int'(st_c), int'(pv[i].st));
            check({tag, ".k.stage"},   int'(st_k), int'(pv[i].stk));
            check({tag, ".k.ready"},   int'(rdy_k), int'(pv[i].rdyk));
            check({tag, ".def.count"}, int'(cnt_d), 0);
        end
        $display("power-on sequence %s: 14 edges applied", tag);
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        // index i = edge i+1 after reset_n rises
        pv[0]  = mk(3'b000, 0, 0, 0);  pv[1]  = mk(3'b000, 0, 0, 0);
        pv[2]  = mk(3'b001, 0, 0, 0);  pv[3]  = mk(3'b001, 0, 1, 0);
        pv[4]  = mk(3'b001, 0, 1, 1);  pv[5]  = mk(3'b001, 0, 1, 1);
        pv[6]  = mk(3'b011, 0, 1, 1);  pv[7]  = mk(3'b011, 0, 1, 1);
        pv[8]  = mk(3'b011, 0, 1, 1);  pv[9]  = mk(3'b011, 0, 1, 1);
        pv[10] = mk(3'b111, 0, 1, 1);  pv[11] = mk(3'b111, 1, 1, 1);
        pv[12] = mk(3'b111, 1, 1, 1);  pv[13] = mk(3'b111, 1, 1, 1);

        m_d = '{0, 0, 0, 0, 0, 0};
        m_c = '{0, 0, 0, 0, 0, 0};
        m_k = '{0, 0, 0, 0, 0, 0};

        // Power-on: reset low for 5 cycles
        rst_n = 1'b1;
        req   = 1'b0;
        #1;
        hard_drop();
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset.def.stage", int'(st_d), 0);
            check("reset.def.ready", int'(rdy_d), 0);
        end
        run_power_table("poweron");

        // Soft-reset handshake with req held 5 cycles after ack
        req = 1'b1;
        step();
        check("soft.E0.stage", int'(st_d), 0);
        check("soft.E0.ready", int'(rdy_d), 0);
        check("soft.E0.count", int'(cnt_d), 1);
        for (int i = 1; i < 8; i++) begin
            step();
            check("soft.hold.ack", int'(ack_d), 0);
        end
        step();
        check("soft.E0+8.ack", int'(ack_d), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("soft.held.ack", int'(ack_d), 1);
            check("soft.held.stage", int'(st_d), 0);
        end
        req = 1'b0;
        step();
        check("soft.E1.ack", int'(ack_d), 0);
        check("soft.E1.stage", int'(st_d), 1);
        for (int i = 1; i < 4; i++) step();
        check("soft.E1+3.stage", int'(st_d), 1);
        step();
        check("soft.E1+4.stage", int'(st_d), 3);
        for (int i = 5; i < 9; i++) step();
        check("soft.E1+8.stage", int'(st_d), 7);
        check("soft.E1+8.ready", int'(rdy_d), 0);
        step();
        check("soft.E1+9.ready", int'(rdy_d), 1);
        $display("soft reset handshake: count=%0d", cnt_d);

        // Mid-sequence hard reset, asynchronous between edges 8 and 9
        hard_drop();
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        #3;
        hard_drop();
        #1;
        check("midrst.def.stage", int'(st_d), 0);
        check("midrst.def.ready", int'(rdy_d), 0);
        compare_all();
        step(); step();
        run_power_table("rerelease");

        // Request held from edge 1 of power-on
        hard_drop();
        step(); step();
        rst_n = 1'b1;
        req   = 1'b1;
        for (int i = 1; i < 12; i++) step();
        check("reqheld.E11.ready", int'(rdy_d), 0);
        step();
        check("reqheld.E12.ready", int'(rdy_d), 1);
        check("reqheld.E12.count", int'(cnt_d), 0);
        step();
        check("reqheld.E13.ready", int'(rdy_d), 0);
        check("reqheld.E13.stage", int'(st_d), 0);
        check("reqheld.E13.count", int'(cnt_d), 1);
        req = 1'b0;   // dropped during the hold: ack pulses one cycle
        for (int i = 0; i < 25; i++) step();
        $display("request held through release: count=%0d", cnt_d);

        // Counter saturation on the 2-bit instance
        hard_drop();
        step(); step();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 100 && rdy_c !== 1'b1; k++) step();
            check("sat.wait_ready", int'(rdy_c), 1);
            req = 1'b1;
            step();
            check("sat.count", int'(cnt_c), sat_exp[j]);
            for (int k = 0; k < 50 && ack_c !== 1'b1; k++) step();
            check("sat.wait_ack", int'(ack_c), 1);
            req = 1'b0;
            step();
            $display("soft reset %0d on 2-bit counter: count=%0d", j + 1, cnt_c);
        end

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (rst_n == 1'b0) begin
                if (r < 40) rst_n = 1'b1;
            end else if (r < 1) begin
                #2;
                hard_drop();
                #1;
                compare_all();
            end
            if ($urandom_range(0, 9) == 0) req = ~req;
            step();
        end
        $display("random phase: 1500 edges applied");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
